// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   FAULT_INSTR      : instruction word presented with a misaligned-target fault
//   fetch_state_e    : fetch FSM states (normal fetch / misaligned-target fault)
package instr_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] FAULT_INSTR      = 32'h0000_0000;

    typedef enum logic {
        StRun,
        StFault
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// In-order prefetch FIFO between instruction memory responses and decode.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : discard all entries (wins over push/pop)
//   i_push, i_data : write one word
//   i_pop          : drop the head entry (ignored when empty)
//   o_data         : head entry
//   o_empty        : no entries held
//   o_count        : number of entries held (0..DEPTH)
module instr_fetch_unit_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != FULL_C);
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited requests to
// instruction memory, in-order prefetch buffering, redirect with stale-response
// discard, and misaligned-redirect fault reporting.
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   o_imemReq/o_imemAddr      : fetch request and word-aligned address
//   i_imemGnt                 : request accepted this cycle
//   i_imemRvalid/i_imemRdata  : in-order response
//   i_redirect/i_redirectPc   : flush and restart fetch at the target
//   o_valid/i_ready           : decode handshake for the head entry
//   o_instr/o_pc/o_misaligned : head entry contents
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemGnt,
    input  logic        i_imemRvalid,
    input  logic [31:0] i_imemRdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_misaligned
);

    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_e  r_state;
    logic [31:0]   r_fpc;
    logic [31:0]   r_head_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;
    logic          r_fault_done;

    logic [CW-1:0] w_occ;
    logic          w_empty;
    logic [31:0]   w_head_word;
    logic          w_credit;
    logic          w_gnt;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_fault_valid;
    logic [CW-1:0] w_inflight_nxt;
    logic [CW-1:0] w_drop_nxt;

    // Credit counts outstanding requests plus buffered words so a response
    // always has a FIFO slot waiting for it.
    assign w_credit   = ({1'b0, r_inflight} + {1'b0, w_occ}) < DEPTH_C;
    // i_rst_n gating lets the first request go out in the first cycle after
    // reset release and drops the request immediately on a mid-stream reset.
    assign o_imemReq  = i_rst_n && (r_state == StRun) && !i_redirect && w_credit;
    assign o_imemAddr = r_fpc;
    assign w_gnt      = o_imemReq && i_imemGnt;

    assign w_drop        = i_imemRvalid && (r_drop_cnt != '0);
    assign w_push        = i_imemRvalid && !w_drop && (r_state == StRun);
    assign w_fault_valid = (r_state == StFault) && (r_drop_cnt == '0) && !r_fault_done;

    assign o_valid      = (r_state == StRun) ? !w_empty : w_fault_valid;
    assign o_instr      = ((r_state == StRun) && !w_empty) ? w_head_word : FAULT_INSTR;
    assign o_pc         = r_head_pc;
    assign o_misaligned = w_fault_valid;
    assign w_pop        = o_valid && i_ready && !i_redirect;

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_gnt && !i_imemRvalid) begin
            w_inflight_nxt = r_inflight + CW'(1);
        end else if (!w_gnt && i_imemRvalid && (r_inflight != '0)) begin
            w_inflight_nxt = r_inflight - CW'(1);
        end
    end

    // On redirect every outstanding response is stale, including one arriving
    // in the redirect cycle itself (which is discarded directly).
    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (i_redirect) begin
            w_drop_nxt = (i_imemRvalid && (r_inflight != '0)) ? r_inflight - CW'(1)
                                                               : r_inflight;
        end else if (w_drop) begin
            w_drop_nxt = r_drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StRun;
            r_fpc        <= RESET_PC;
            r_head_pc    <= RESET_PC;
            r_inflight   <= '0;
            r_drop_cnt   <= '0;
            r_fault_done <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_drop_cnt <= w_drop_nxt;
            if (i_redirect) begin
                r_fpc        <= i_redirectPc;
                r_head_pc    <= i_redirectPc;
                r_fault_done <= 1'b0;
                r_state      <= (i_redirectPc[1:0] != 2'b00) ? StFault : StRun;
            end else begin
                if (w_gnt) begin
                    r_fpc <= r_fpc + 32'd4;
                end
                case (r_state)
                    StRun: begin
                        if (w_pop) begin
                            r_head_pc <= r_head_pc + 32'd4;
                        end
                    end
                    StFault: begin
                        // The fault entry is shown once; afterwards wait for a redirect.
                        if (w_pop) begin
                            r_fault_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    instr_fetch_unit_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (w_push),
        .i_data  (i_imemRdata),
        .i_pop   (w_pop),
        .o_data  (w_head_word),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected decode
// entries into a queue; a monitor pops and compares on every accepted entry.
// A behavioural memory grants every request and answers after `lat` cycles.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_imemReq    (req),
        .o_imemAddr   (addr),
        .i_imemGnt    (gnt),
        .i_imemRvalid (rvalid),
        .i_imemRdata  (rdata),
        .i_redirect   (redirect),
        .i_redirectPc (redirect_pc),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_instr      (instr),
        .o_pc         (pc),
        .o_misaligned (mis)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned mcyc  = 0;
    int unsigned pcyc  = 0;
    int unsigned lat   = 1;
    int unsigned n_gnt = 0;
    int unsigned n_pops = 0;
    int unsigned first_pop_cyc = 0;
    int unsigned last_pop_cyc  = 0;
    int unsigned start_cyc     = 0;

    // Memory image: upper half tags the word, lower half is the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: base + 32'(4 * i), instr: mem_word(base + 32'(4 * i)), mis: 1'b0});
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_drained(input int max, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max) begin
            ready = 1'b1;
            cyc_step();
            k++;
        end
        ready = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d entries left expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic redirect_to(input logic [31:0] target, input bit chk_bubble);
        redirect    = 1'b1;
        redirect_pc = target;
        #1;
        check("req_in_redirect", {31'b0, req}, 32'd0);
        cyc_step();
        redirect = 1'b0;
        if (chk_bubble) begin
            check("valid_after_redirect", {31'b0, valid}, 32'd0);
        end
    endtask

    always @(posedge clk) pcyc++;

    // Memory model: decide grant/response mid-cycle, held until the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            rvalid = 1'b0;
            rdata  = 32'h0;
        end else begin
            rvalid = 1'b0;
            if (pend_q.size() != 0 && pend_q[0].due <= mcyc) begin
                rvalid = 1'b1;
                rdata  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
            if (req && gnt) begin
                pend_q.push_back('{addr: addr, due: mcyc + lat});
                n_gnt++;
            end
        end
        mcyc++;
    end

    // Monitor: every accepted entry must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && !redirect && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pc %h expected no entry", pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pc", pc, mon_e.pc);
                check("instr", instr, mon_e.instr);
                check("misaligned", {31'b0, mis}, {31'b0, mon_e.mis});
            end
            if (n_pops == 0) begin
                first_pop_cyc = pcyc;
            end
            last_pop_cyc = pcyc;
            n_pops++;
        end
    end

    initial begin
        rst_n       = 1'b0;
        gnt         = 1'b1;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) cyc_step();

        // Reset state
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_addr", addr, 32'h0000_0000);
        check("rst_instr", instr, 32'h0000_0000);
        check("rst_mis", {31'b0, mis}, 32'd0);
        check("rst_pc", pc, 32'h0000_0000);

        // Streaming, 1-cycle memory, decode always ready
        rst_n     = 1'b1;
        start_cyc = pcyc;
        n_pops    = 0;
        #1;
        check("first_req", {31'b0, req}, 32'd1);
        check("first_addr", addr, 32'h0000_0000);
        push_seq(32'h0000_0000, 16);
        run_until_drained(100, "stream");
        check("startup_cycles", first_pop_cyc - start_cyc, 32'd2);
        check("no_bubbles", last_pop_cyc - first_pop_cyc, 32'd15);

        // Redirect in a cycle with a response and a pop
        push_seq(32'h0000_0200, 12);
        redirect_to(32'h0000_0200, 1'b1);
        begin
            int k;
            k = 0;
            while (exp_q.size() > 6 && k < 40) begin
                ready = 1'b1;
                cyc_step();
                k++;
            end
            check("reach_midstream", exp_q.size(), 32'd6);
        end
        check("valid_at_redirect", {31'b0, valid}, 32'd1);
        exp_q.delete();
        push_seq(32'h0000_0300, 4);
        redirect_to(32'h0000_0300, 1'b1);
        run_until_drained(50, "redirect_rvalid_pop");

        // Stalled decode: exactly DEPTH grants, then no request
        rst_n = 1'b0;
        cyc_step();
        cyc_step();
        rst_n = 1'b1;
        n_gnt = 0;
        repeat (10) cyc_step();
        check("gnt_while_stalled", n_gnt, 32'd4);
        check("req_when_full", {31'b0, req}, 32'd0);
        check("valid_when_full", {31'b0, valid}, 32'd1);
        push_seq(32'h0000_0000, 8);
        run_until_drained(60, "release");

        // Reset in the middle of buffered fetch
        repeat (4) cyc_step();
        check("buffered_before_reset", {31'b0, valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("valid_in_reset", {31'b0, valid}, 32'd0);
        check("req_in_reset", {31'b0, req}, 32'd0);
        cyc_step();
        cyc_step();
        rst_n = 1'b1;
        #1;
        check("restart_req", {31'b0, req}, 32'd1);
        check("restart_addr", addr, 32'h0000_0000);
        push_seq(32'h0000_0000, 4);
        run_until_drained(40, "after_reset");

        // 3-cycle memory: redirect with three requests outstanding
        lat = 3;
        repeat (6) cyc_step();
        redirect_to(32'h0000_0080, 1'b1);
        begin
            int k;
            k = 0;
            while (pend_q.size() < 3 && k < 20) begin
                cyc_step();
                k++;
            end
            check("three_inflight", pend_q.size(), 32'd3);
        end
        exp_q.delete();
        push_seq(32'h0000_0100, 4);
        redirect_to(32'h0000_0100, 1'b1);
        run_until_drained(60, "lat3_redirect");

        // Misaligned redirect target
        exp_q.delete();
        exp_q.push_back('{pc: 32'h0000_0102, instr: 32'h0000_0000, mis: 1'b1});
        redirect_to(32'h0000_0102, 1'b0);
        n_gnt = 0;
        run_until_drained(40, "fault_entry");
        ready = 1'b1;
        repeat (5) cyc_step();
        ready = 1'b0;
        check("no_gnt_in_fault", n_gnt, 32'd0);
        check("fault_held_off", {31'b0, valid}, 32'd0);
        check("no_req_in_fault", {31'b0, req}, 32'd0);

        // Aligned redirect leaves the fault
        lat = 1;
        push_seq(32'h0000_0200, 4);
        redirect_to(32'h0000_0200, 1'b1);
        run_until_drained(40, "resume_after_fault");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
